// File: rtl/control_pkg.sv
// Shared control types for the pipeline hazard logic.
package control_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MDU_BUSY = 1'b1
  } hazard_state_e;

  localparam int unsigned REG_IDX_W = 5;

  // True when a non-zero destination feeds a source register that ID actually reads.
  function automatic logic src_match(input logic [REG_IDX_W-1:0] rd,
                                     input logic [REG_IDX_W-1:0] rs1,
                                     input logic [REG_IDX_W-1:0] rs2,
                                     input logic                 uses_rs2);
    return (rd != 5'd0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Saturating increment
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush control: MDU busy FSM, load-use and branch hazards, taken-branch flush.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_controller
  import control_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        if_id_rs1,
  input  logic [4:0]        if_id_rs2,
  input  logic              if_id_uses_rs2,
  input  logic              if_id_is_branch,
  input  logic [4:0]        id_ex_rd,
  input  logic              id_ex_reg_write,
  input  logic              id_ex_mem_read,
  input  logic [4:0]        ex_mem_rd,
  input  logic              ex_mem_mem_read,
  input  logic              branch_taken,
  input  logic              mdu_start,
  input  logic              mdu_done,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mdu_timeout,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  // The counter value during the release cycle, and the one before it where the flag is raised.
  localparam logic [7:0] CNT_LAST = 8'(MDU_TIMEOUT - 1);
  localparam logic [7:0] CNT_WARN = 8'(MDU_TIMEOUT - 2);

  hazard_state_e state_r, state_nxt_s;
  logic [7:0]    busy_cnt_r, busy_cnt_nxt_s;
  logic          timeout_r, timeout_nxt_s;
  logic          mdu_stall_s;
  logic          load_use_s;
  logic          branch_hz_s;

  // State, busy counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      busy_cnt_r <= 8'd0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_cnt_r <= busy_cnt_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  // MDU next-state logic; mdu_start is only looked at in IDLE
  always_comb begin
    state_nxt_s    = state_r;
    busy_cnt_nxt_s = busy_cnt_r;
    timeout_nxt_s  = timeout_r;
    mdu_stall_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (mdu_start && !mdu_done) begin
          mdu_stall_s    = 1'b1;
          busy_cnt_nxt_s = 8'd0;
          state_nxt_s    = MDU_BUSY;
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      MDU_BUSY: begin
        if (busy_cnt_r == CNT_LAST) begin
          state_nxt_s = IDLE;
        end else if (mdu_done) begin
          state_nxt_s = IDLE;
        end else begin
          mdu_stall_s    = 1'b1;
          busy_cnt_nxt_s = busy_cnt_r + 8'd1;
          if (busy_cnt_r == CNT_WARN) begin
            timeout_nxt_s = 1'b1;
          end else begin
            timeout_nxt_s = timeout_r;
          end
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        busy_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  assign load_use_s  = id_ex_mem_read &&
                       src_match(id_ex_rd, if_id_rs1, if_id_rs2, if_id_uses_rs2);
  assign branch_hz_s = if_id_is_branch &&
                       ((id_ex_reg_write && src_match(id_ex_rd, if_id_rs1, if_id_rs2, if_id_uses_rs2)) ||
                        (ex_mem_mem_read && src_match(ex_mem_rd, if_id_rs1, if_id_rs2, if_id_uses_rs2)));

  // Priority resolution: MDU stall, then data hazard, then taken-branch flush
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (rst) begin
      pc_stall = 1'b0;
    end else if (mdu_stall_s) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use_s || branch_hz_s) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end else begin
      if_id_flush = 1'b0;
    end
  end

  assign mdu_timeout = timeout_r;

`ifdef HAZARD_PERF_EN
  logic any_flush_s;
  assign any_flush_s = if_id_flush | id_ex_flush | ex_mem_flush;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (perf_stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (any_flush_s),
    .count (perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = {PERF_W{1'b0}};
  assign perf_flush_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with a cycle-level behavioural model.
module tb_hazard_controller;

  localparam int T  = 8;
  localparam int PW = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd, ex_mem_rd;
  logic if_id_uses_rs2, if_id_is_branch, id_ex_reg_write, id_ex_mem_read;
  logic ex_mem_mem_read, branch_taken, mdu_start, mdu_done;
  logic pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_flush;
  logic mdu_timeout;
  logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;

  hazard_controller #(.MDU_TIMEOUT(T), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_uses_rs2(if_id_uses_rs2), .if_id_is_branch(if_id_is_branch),
    .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_rd(ex_mem_rd), .ex_mem_mem_read(ex_mem_mem_read),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mdu_timeout(mdu_timeout),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: MDU occupancy as "stall cycles spent so far" rather than a state machine.
  bit m_active = 1'b0;
  int m_cycles = 0;
  bit m_flag   = 1'b0;
  int m_pstall = 0;
  int m_pflush = 0;
  bit e_mdu, e_hz, e_bt;
  int e_ps, e_pf;

  function automatic bit feeds(input logic [4:0] r);
    return (r != 5'd0) && ((r == if_id_rs1) || (if_id_uses_rs2 && (r == if_id_rs2)));
  endfunction

  always @(negedge clk) begin
    e_mdu = !rst && ((!m_active && mdu_start && !mdu_done) ||
                     (m_active && !mdu_done && (m_cycles < T)));
    e_hz  = !rst && !e_mdu &&
            ((id_ex_mem_read && feeds(id_ex_rd)) ||
             (if_id_is_branch && ((id_ex_reg_write && feeds(id_ex_rd)) ||
                                  (ex_mem_mem_read && feeds(ex_mem_rd)))));
    e_bt  = !rst && !e_mdu && !e_hz && branch_taken;
`ifdef HAZARD_PERF_EN
    e_ps = m_pstall;
    e_pf = m_pflush;
`else
    e_ps = 0;
    e_pf = 0;
`endif
    check("m_pc_stall",     32'(pc_stall),     32'(e_mdu | e_hz));
    check("m_if_id_stall",  32'(if_id_stall),  32'(e_mdu | e_hz));
    check("m_id_ex_stall",  32'(id_ex_stall),  32'(e_mdu));
    check("m_ex_mem_flush", 32'(ex_mem_flush), 32'(e_mdu));
    check("m_id_ex_flush",  32'(id_ex_flush),  32'(e_hz));
    check("m_if_id_flush",  32'(if_id_flush),  32'(e_bt));
    check("m_mdu_timeout",  32'(mdu_timeout),  32'(m_flag));
    check("m_perf_stall",   32'(perf_stall_cnt), 32'(e_ps));
    check("m_perf_flush",   32'(perf_flush_cnt), 32'(e_pf));
    if (rst) begin
      m_active = 1'b0; m_cycles = 0; m_flag = 1'b0; m_pstall = 0; m_pflush = 0;
    end else begin
      if ((e_mdu || e_hz) && m_pstall < PMAX) m_pstall++;
      if ((e_mdu || e_hz || e_bt) && m_pflush < PMAX) m_pflush++;
      if (!m_active) begin
        if (mdu_start && !mdu_done) begin
          m_active = 1'b1;
          m_cycles = 1;
        end
      end else if (m_cycles >= T || mdu_done) begin
        m_active = 1'b0;
      end else begin
        m_cycles++;
        if (m_cycles == T) m_flag = 1'b1;
      end
    end
  end

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; if_id_uses_rs2 = 1'b0; if_id_is_branch = 1'b0;
    id_ex_rd = 5'd0; id_ex_reg_write = 1'b0; id_ex_mem_read = 1'b0;
    ex_mem_rd = 5'd0; ex_mem_mem_read = 1'b0;
    branch_taken = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic load_use_x5();
    id_ex_rd = 5'd5; id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1;
    if_id_rs1 = 5'd5; if_id_rs2 = 5'd1; if_id_uses_rs2 = 1'b1;
  endtask

  int n;

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    mid();
    check("reset_pc_stall", 32'(pc_stall), 32'd0);
    check("reset_timeout",  32'(mdu_timeout), 32'd0);
    nxt();
    rst = 1'b0;

    // lw x5 in EX, add x6,x5,x1 in ID
    load_use_x5();
    mid();
    check("lu_pc_stall",    32'(pc_stall),    32'd1);
    check("lu_if_id_stall", 32'(if_id_stall), 32'd1);
    check("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    check("lu_id_ex_stall", 32'(id_ex_stall), 32'd0);
    nxt();
    clr(); ex_mem_rd = 5'd5; ex_mem_mem_read = 1'b1; if_id_rs1 = 5'd5; if_id_rs2 = 5'd1; if_id_uses_rs2 = 1'b1;
    mid();
    check("lu_released", 32'(pc_stall), 32'd0);
    nxt();

    // lw x7 then beq x7,x0 stalls two cycles
    clr(); n = 0;
    id_ex_rd = 5'd7; id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1;
    if_id_is_branch = 1'b1; if_id_rs1 = 5'd7; if_id_rs2 = 5'd0; if_id_uses_rs2 = 1'b1;
    mid(); n += int'(pc_stall); nxt();
    id_ex_rd = 5'd0; id_ex_mem_read = 1'b0; id_ex_reg_write = 1'b0;
    ex_mem_rd = 5'd7; ex_mem_mem_read = 1'b1;
    mid(); n += int'(pc_stall); nxt();
    ex_mem_rd = 5'd0; ex_mem_mem_read = 1'b0;
    mid();
    check("br_third_cycle", 32'(pc_stall), 32'd0);
    check("br_stall_count", 32'(n), 32'd2);
    nxt();
    clr(); if_id_is_branch = 1'b1; id_ex_reg_write = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0;
    mid();
    check("br_x0_no_stall", 32'(pc_stall), 32'd0);
    nxt();

    // taken branch against a hazard, then alone
    clr(); load_use_x5(); branch_taken = 1'b1;
    mid();
    check("bt_hz_if_id_flush", 32'(if_id_flush), 32'd0);
    check("bt_hz_id_ex_flush", 32'(id_ex_flush), 32'd1);
    nxt();
    clr(); branch_taken = 1'b1;
    mid();
    check("bt_if_id_flush", 32'(if_id_flush), 32'd1);
    check("bt_no_stall",    32'(pc_stall),    32'd0);
    nxt();
    clr();
    mid();
    check("bt_one_cycle", 32'(if_id_flush), 32'd0);
    nxt();

    // MDU op completing 5 cycles after start
    clr(); mdu_start = 1'b1; n = 0;
    mid(); n += int'(pc_stall & ex_mem_flush); nxt();
    mdu_start = 1'b1; load_use_x5();
    mid(); n += int'(pc_stall & ex_mem_flush);
    check("mdu_prio_id_ex_flush", 32'(id_ex_flush), 32'd0);
    check("mdu_id_ex_stall",      32'(id_ex_stall), 32'd1);
    nxt();
    clr();
    repeat (3) begin mid(); n += int'(pc_stall & ex_mem_flush); nxt(); end
    mdu_done = 1'b1;
    mid();
    check("mdu_done_stall", 32'(pc_stall),     32'd0);
    check("mdu_done_flush", 32'(ex_mem_flush), 32'd0);
    check("mdu_stall_count", 32'(n), 32'd5);
    nxt();
    clr();
    mid();
    check("mdu_idle_after", 32'(pc_stall), 32'd0);
    nxt();

    // MDU op that never completes
    clr(); mdu_start = 1'b1; n = 0;
    repeat (12) begin mid(); n += int'(pc_stall); nxt(); mdu_start = 1'b0; end
    mid();
    check("to_stall_count", 32'(n), 32'd8);
    check("to_flag",        32'(mdu_timeout), 32'd1);
    check("to_released",    32'(pc_stall), 32'd0);
    nxt();
    rst = 1'b1; nxt(); rst = 1'b0;
    mid();
    check("to_cleared", 32'(mdu_timeout), 32'd0);
    nxt();

    // 20 hazard stall cycles saturate the 4-bit counters
    rst = 1'b1; nxt(); rst = 1'b0;
    clr(); load_use_x5();
    repeat (20) nxt();
    clr();
    mid();
`ifdef HAZARD_PERF_EN
    check("perf_stall_sat", 32'(perf_stall_cnt), 32'd15);
    check("perf_flush_sat", 32'(perf_flush_cnt), 32'd15);
`else
    check("perf_stall_tied", 32'(perf_stall_cnt), 32'd0);
    check("perf_flush_tied", 32'(perf_flush_cnt), 32'd0);
`endif
    nxt();

    // reset arriving while MDU_BUSY
    mdu_start = 1'b1; nxt(); mdu_start = 1'b0; nxt();
    mid();
    check("rst_pre_busy", 32'(pc_stall), 32'd1);
    rst = 1'b1;
    mid();
    check("rst_comb_stall", 32'(pc_stall), 32'd0);
    nxt();
    mid();
    check("rst_ex_mem_flush", 32'(ex_mem_flush),   32'd0);
    check("rst_perf_stall",   32'(perf_stall_cnt), 32'd0);
    check("rst_timeout",      32'(mdu_timeout),    32'd0);
    nxt();
    rst = 1'b0;
    mid();
    check("rst_back_idle", 32'(pc_stall), 32'd0);
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter MDU_TIMEOUT, default 64, max cycles spent in MDU_BUSY before abort (range 2..255).
REQ-002 SHALL have parameter PERF_W, default 32, width of each performance counter.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports if_id_uses_rs2, if_id_is_branch  in  1 each  ID reads rs2; ID holds a branch resolved in ID.
REQ-007 SHALL have ports id_ex_rd  in  5, and id_ex_reg_write, id_ex_mem_read  in  1 each  EX destination, EX writes the register file, EX is a load.
REQ-008 SHALL have ports ex_mem_rd  in  5, and ex_mem_mem_read  in  1  MEM destination; MEM is a load.
REQ-009 SHALL have port branch_taken  in  1  ID compare resolved taken.
REQ-010 SHALL have ports mdu_start, mdu_done  in  1 each  multi-cycle op enters EX; MDU result ready.
REQ-011 SHALL have ports pc_stall, if_id_stall, id_ex_stall  out  1 each  hold the PC and the named pipeline register.
REQ-012 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble into the named register.
REQ-013 SHALL have port mdu_timeout  out  1  sticky error flag.
REQ-014 SHALL have ports perf_stall_cnt, perf_flush_cnt  out  PERF_W each  performance counters.

Function
REQ-015 SHALL have a two-state FSM (IDLE, MDU_BUSY) plus an 8-bit busy counter; all stall and flush outputs are combinational from state and inputs (0-cycle latency).
REQ-016 SHALL, in IDLE with mdu_start=1 and mdu_done=0, assert pc_stall, if_id_stall, id_ex_stall and ex_mem_flush, clear the busy counter and move to MDU_BUSY.
REQ-017 SHALL, in IDLE with mdu_start=1 and mdu_done=1, produce no stall and remain in IDLE.
REQ-018 SHALL, in MDU_BUSY with mdu_done=0, assert the same four signals as REQ-016 and increment the busy counter.
REQ-019 SHALL, in MDU_BUSY with mdu_done=1, deassert all four signals in that cycle and return to IDLE.
REQ-020 SHALL, when the busy counter reaches MDU_TIMEOUT-1 without mdu_done, set mdu_timeout (held until rst), release the stall on the next cycle and return to IDLE.
REQ-021 SHALL ignore mdu_start while in MDU_BUSY.
REQ-022 SHALL detect a load-use hazard when id_ex_mem_read=1, id_ex_rd!=0, and id_ex_rd equals if_id_rs1, or equals if_id_rs2 with if_id_uses_rs2=1.
REQ-023 SHALL detect a branch hazard when if_id_is_branch=1 and either of these holds: id_ex_reg_write=1 with id_ex_rd!=0 matching a used source; or ex_mem_mem_read=1 with ex_mem_rd!=0 matching a used source.
REQ-024 SHALL, on either hazard while not MDU-stalled, assert pc_stall and if_id_stall plus id_ex_flush, ending when the pipeline advances. A load followed by a dependent branch therefore stalls exactly 2 cycles.
REQ-025 SHALL treat register 0 as never hazardous.
REQ-026 SHALL, on branch_taken=1 with no MDU stall and no hazard, assert if_id_flush for one cycle.
REQ-027 SHALL ignore branch_taken while a hazard or MDU stall is active.
REQ-028 SHALL apply priority: MDU stall > load-use/branch hazard > taken-branch flush.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, busy counter 0, mdu_timeout 0 and both perf counters 0.
REQ-030 SHALL, while rst=1, drive all stall and flush outputs to 0, including when rst arrives mid-MDU_BUSY.

Configuration
REQ-031 SHALL, with HAZARD_PERF_EN defined, increment perf_stall_cnt on every cycle pc_stall=1 and perf_flush_cnt on every cycle with any flush asserted, both saturating at all-ones.
REQ-032 SHALL, without HAZARD_PERF_EN, keep both perf ports present and tied to 0, with no counter registers.

Structure
REQ-033 SHALL place the hazard_state_e enum (IDLE, MDU_BUSY) in control_pkg.
REQ-034 SHALL implement the perf counters as a sub-module sat_counter (parameter W; ports clk, rst, inc, count), instantiated only under HAZARD_PERF_EN.

Verification
REQ-035 SHALL cover: lw x5 in EX, add x6,x5,x1 in ID -> pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle.
REQ-036 SHALL cover: lw x7 then beq x7,x0 -> pc_stall for exactly 2 consecutive cycles; beq with id_ex_rd=0 -> no stall.
REQ-037 SHALL cover: mdu_start, then mdu_done 5 cycles later -> stall and ex_mem_flush high for 5 cycles, low in the done cycle, state IDLE.
REQ-038 SHALL cover: mdu_start with no done, MDU_TIMEOUT=8 -> mdu_timeout=1 after 8 stall cycles and stall released; rst clears the flag.
REQ-039 SHALL cover: branch_taken=1 coincident with a load-use hazard -> no if_id_flush; branch_taken alone -> if_id_flush=1 for 1 cycle.
REQ-040 SHALL cover: with HAZARD_PERF_EN and PERF_W=4, 20 stall cycles -> perf_stall_cnt=15; rst asserted mid-MDU_BUSY -> all outputs 0 on the next edge.
